alu_seq: RTL

Parametrised multi-cycle successor to the sisc arithmetic logic unit. It keeps the existing function-code map and adds a start/done handshake, iterative shift and rotate (one bit per cycle), an optional iterative multiply, and a registered 4-bit status word. It sits between the register file and the writeback mux; control holds the writeback while `busy` is high.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_iter_unit.sv | 80 ++++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: function codes, FSM states,
// iteration kinds and status-word bit positions.
package alu_pkg;

  localparam logic [3:0] ADD  = 4'd1;
  localparam logic [3:0] SUB  = 4'd2;
  localparam logic [3:0] NOTA = 4'd4;
  localparam logic [3:0] OR   = 4'd5;
  localparam logic [3:0] AND  = 4'd6;
  localparam logic [3:0] XOR  = 4'd7;
  localparam logic [3:0] ROTR = 4'd8;
  localparam logic [3:0] ROTL = 4'd9;
  localparam logic [3:0] SHR  = 4'd10;
  localparam logic [3:0] SHL  = 4'd11;
  localparam logic [3:0] MUL  = 4'd12;

  localparam int ST_C = 3;
  localparam int ST_V = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

  typedef enum logic [2:0] {IK_ROTR, IK_ROTL, IK_SHR, IK_SHL, IK_MUL} iter_kind_t;

endpackage

// File: rtl/alu_iter_unit.sv
// One-bit-per-cycle shift/rotate engine with down-counter; adds a shift-add
// multiplier accumulator when ALU_SEQ_MUL_EN is defined.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  iter_kind_t       kind,
  input  logic [CNT_W-1:0] n,
`ifdef ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] b,
`endif
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] nxt,
  output logic             last
);

  iter_kind_t       kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] val_q;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mb_q;
  logic [WIDTH-1:0] acc_q;
`endif

  // nxt is the value after the step taken this cycle; the top captures it on last
  always_comb begin
    nxt = val_q;
    case (kind_q)
      IK_ROTR: nxt = {val_q[0], val_q[WIDTH-1:1]};
      IK_ROTL: nxt = {val_q[WIDTH-2:0], val_q[WIDTH-1]};
      IK_SHR:  nxt = {1'b0, val_q[WIDTH-1:1]};
      IK_SHL:  nxt = {val_q[WIDTH-2:0], 1'b0};
`ifdef ALU_SEQ_MUL_EN
      IK_MUL:  nxt = acc_q + (mb_q[0] ? val_q : '0);
`endif
      default: nxt = val_q;
    endcase
  end

  assign last = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= n;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      kind_q <= kind;
      val_q  <= a;
`ifdef ALU_SEQ_MUL_EN
      mb_q   <= b;
      acc_q  <= '0;
`endif
    end else if (cnt_q != '0) begin
`ifdef ALU_SEQ_MUL_EN
      if (kind_q == IK_MUL) begin
        acc_q <= nxt;
        val_q <= {val_q[WIDTH-2:0], 1'b0};
        mb_q  <= {1'b0, mb_q[WIDTH-1:1]};
      end else begin
        val_q <= nxt;
      end
`else
      val_q <= nxt;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with start/done handshake, iterative shifts/rotates and a
// registered {C,V,N,Z} status word. Optional multiply: ALU_SEQ_MUL_EN.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rsa,
  input  logic [WIDTH-1:0] rsb,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       stat,
  output logic             stat_en
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = SHW + 1;

  state_t                  state_q, state_d;
  logic [3:0]              funct;
  logic signed [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0]        opb;
  logic                    is_sub;
  logic [WIDTH:0]          addsub;
  logic [WIDTH-1:0]        res_now;
  logic                    iter_go;
  iter_kind_t              kind_now;
  logic [CNT_W-1:0]        n_now;
  logic                    stat_upd_now, stat_upd_q;
  logic [3:0]              stat_now;
  logic                    accept, last;
  logic [WIDTH-1:0]        iter_nxt;

  // V flags signed overflow; N is the sign the ideal (unbounded) result would have
  function automatic logic [3:0] calc_stat(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [WIDTH:0]   r,
                                           input logic             sub);
    logic v;
    logic [3:0] s;
    if (sub) v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    else     v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    s       = '0;
    s[ST_C] = r[WIDTH];
    s[ST_V] = v;
    s[ST_N] = r[WIDTH-1] ^ v;
    s[ST_Z] = (r[WIDTH-1:0] == '0);
    return s;
  endfunction

  always_comb begin
    funct    = imm[3:0];
    imm_sx   = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    opb      = alu_op[0] ? imm_sx : rsb;
    is_sub   = !alu_op[0] && (funct == SUB);
    addsub   = is_sub ? ({1'b0, rsa} - {1'b0, opb}) : ({1'b0, rsa} + {1'b0, opb});
    res_now  = '0;
    iter_go  = 1'b0;
    kind_now = IK_ROTR;
    n_now    = '0;
    if (alu_op[0]) begin
      res_now = addsub[WIDTH-1:0];
    end else begin
      case (funct)
        ADD, SUB: res_now = addsub[WIDTH-1:0];
        NOTA:     res_now = ~rsa;
        OR:       res_now = rsa | rsb;
        AND:      res_now = rsa & rsb;
        XOR:      res_now = rsa ^ rsb;
        ROTR, ROTL: begin
          kind_now = (funct == ROTR) ? IK_ROTR : IK_ROTL;
          n_now    = {1'b0, rsb[SHW-1:0]};
          res_now  = rsa;
          iter_go  = |rsb[SHW-1:0];
        end
        SHR, SHL: begin
          kind_now = (funct == SHR) ? IK_SHR : IK_SHL;
          n_now    = {1'b0, rsb[SHW-1:0]};
          // rsb >= WIDTH shifts everything out: answer directly, no iterations
          if (|rsb[WIDTH-1:SHW]) begin
            res_now = '0;
          end else begin
            res_now = rsa;
            iter_go = |rsb[SHW-1:0];
          end
        end
`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          kind_now = IK_MUL;
          n_now    = CNT_W'(WIDTH);
          iter_go  = 1'b1;
        end
`endif
        default: res_now = '0;
      endcase
    end
    stat_upd_now = (alu_op == 2'b00) && ((funct == ADD) || (funct == SUB));
    stat_now     = calc_stat(rsa, opb, addsub, is_sub);
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (accept && iter_go),
    .kind (kind_now),
    .n    (n_now),
`ifdef ALU_SEQ_MUL_EN
    .b    (rsb),
`endif
    .a    (rsa),
    .nxt  (iter_nxt),
    .last (last)
  );

  always_comb begin
    accept  = start && (state_q != EXEC);
    state_d = state_q;
    unique case (state_q)
      EXEC:    if (last) state_d = FIN;
      default: state_d = accept ? (iter_go ? EXEC : FIN) : IDLE;
    endcase
    busy    = (state_q == EXEC);
    done    = (state_q == FIN);
    stat_en = done && stat_upd_q;
  end

  // Result/status stage: written when entering FIN so they are valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_result <= '0;
      stat       <= '0;
      stat_upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        stat_upd_q <= stat_upd_now;
        if (!iter_go)     alu_result <= res_now;
        if (stat_upd_now) stat       <= stat_now;
      end else if (busy && last) begin
        alu_result <= iter_nxt;
      end
    end
  end

endmodule
